// File: rtl/cla_serial_seq_if.sv
// Handshake/bus bundle for cla_serial_seq.
// Both sides use valid/ready: a transfer happens on the rising clock edge where
// valid and ready are both high. A producer holds valid and its data until that
// edge. ready and valid never depend combinationally on the other party's signals.
// fsm_state carries the sequencer state for observation.
interface cla_serial_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic [1:0]       fsm_state;

  // Producer/consumer side
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy, fsm_state
  );

  // Sequencer side
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy, fsm_state
  );
endinterface

// File: rtl/cla_serial_seq.sv
// cla_serial_seq: adds two WIDTH-bit operands two bits per clock through a
// 2-bit carry-lookahead slice, rippling the slice carry through a register.
// Optional feature macro CLA_SEQ_SEG7_EN adds a registered active-low 7-segment
// hex readout (seg = {g,f,e,d,c,b,a}) of sum[3:0], refreshed on entry to DONE.
module cla_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  cla_serial_seq_if.slave bus
`ifdef CLA_SEQ_SEG7_EN
  ,
  output logic [6:0] seg
`endif
);

  localparam int SLICES = WIDTH / 2;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic             cout_q;
  logic [CNT_W-1:0] count;
  logic             last_slice;

  // Slice signals
  logic [1:0] g;
  logic [1:0] p;
  logic [1:0] s;
  logic       c1;
  logic       c2;

  assign last_slice = (count == CNT_W'(SLICES - 1));

  // 2-bit lookahead slice: both carries computed directly from g/p and carry-in
  always_comb begin
    g  = a_sh[1:0] & b_sh[1:0];
    p  = a_sh[1:0] ^ b_sh[1:0];
    c1 = g[0] | (p[0] & carry);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    s  = p ^ {c1, carry};
  end

  // New slice bits enter at the MSB so the sum ends up aligned after SLICES shifts
  if (WIDTH == 2) begin : g_sum_narrow
    assign sum_next = s;
  end else begin : g_sum_wide
    assign sum_next = {s, sum_q[WIDTH-1:2]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last_slice)    state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand shift registers, carry, slice counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            count <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 2;
          b_sh  <= b_sh >> 2;
          sum_q <= sum_next;
          carry <= c2;
          count <= count + CNT_W'(1);
          if (last_slice) cout_q <= c2;
        end
        default: ;
      endcase
    end
  end

  // Handshake and status flags come from state alone
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.fsm_state = state;

`ifdef CLA_SEQ_SEG7_EN
  logic [3:0] nib;

  if (WIDTH >= 4) begin : g_nib_wide
    assign nib = sum_next[3:0];
  end else begin : g_nib_narrow
    assign nib = {2'b00, sum_next};
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Display register loads the final sum nibble as the FSM enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          seg <= 7'b1000000;
    else if (state == RUN && last_slice) seg <= hex7(nib);
  end
`endif

endmodule

// File: tb/tb_cla_serial_seq.sv
// Bench for cla_serial_seq: an 8-bit instance for directed, backpressure,
// reset and random tests, and a 2-bit instance for exhaustive checking.
module tb_cla_serial_seq;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [8:0] exp_q[$];

  cla_serial_seq_if #(.WIDTH(8)) i8 ();
  cla_serial_seq_if #(.WIDTH(2)) i2 ();

`ifdef CLA_SEQ_SEG7_EN
  logic [6:0] seg8;
  logic [6:0] seg2;
`endif

  cla_serial_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(i8)
`ifdef CLA_SEQ_SEG7_EN
    , .seg(seg8)
`endif
  );

  cla_serial_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(i2)
`ifdef CLA_SEQ_SEG7_EN
    , .seg(seg2)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: standard 7-segment active-low glyph table
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[v];
  endfunction

  // Reference: plain wide addition
  function automatic logic [8:0] add8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // Driver: present operands, wait for acceptance, then count edges to out_valid
  task automatic start8(input logic [7:0] ta, input logic [7:0] tbv, input logic tc, output int lat);
    @(negedge clk);
    i8.a = ta; i8.b = tbv; i8.cin = tc; i8.in_valid = 1'b1; i8.out_ready = 1'b0;
    @(posedge clk);
    #1 i8.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!i8.out_valid && lat < 40);
  endtask

  // Driver: accept the pending result
  task automatic pop8();
    @(negedge clk);
    i8.out_ready = 1'b1;
    @(posedge clk);
    #1 i8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if (i8.in_ready !== 1'b1 || i8.out_valid !== 1'b0 || i8.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: got rdy=%b vld=%b busy=%b, need 1/0/0", i8.in_ready, i8.out_valid, i8.busy);
    end
    n_vec++;
    if (i8.sum !== 8'h00 || i8.cout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sum: got %b/%h, need 0/00", i8.cout, i8.sum);
    end
`ifdef CLA_SEQ_SEG7_EN
    n_vec++;
    if (seg8 !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_seg: got %b, need 1000000", seg8);
    end
`endif
  endtask

  task automatic test_directed();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vc [5];
    logic [8:0] e;
    int lat;
    va = '{8'hFF, 8'h5A, 8'h00, 8'h12, 8'hAA};
    vb = '{8'h01, 8'hA5, 8'h00, 8'h21, 8'h55};
    vc = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
    for (int i = 0; i < 5; i++) begin
      e = add8(va[i], vb[i], vc[i]);
      start8(va[i], vb[i], vc[i], lat);
      n_vec++;
      if (lat != 4) begin
        n_err++;
        $display("FAIL dir_latency[%0d]: got %0d edges, need 4", i, lat);
      end
      n_vec++;
      if ({i8.cout, i8.sum} !== e) begin
        n_err++;
        $display("FAIL dir_sum[%0d]: got %b/%h, need %b/%h", i, i8.cout, i8.sum, e[8], e[7:0]);
      end
`ifdef CLA_SEQ_SEG7_EN
      n_vec++;
      if (seg8 !== glyph(e[3:0])) begin
        n_err++;
        $display("FAIL dir_seg[%0d]: got %b, need %b", i, seg8, glyph(e[3:0]));
      end
`endif
      pop8();
      n_vec++;
      if (i8.out_valid !== 1'b0 || i8.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL dir_return_idle[%0d]: got vld=%b rdy=%b, need 0/1", i, i8.out_valid, i8.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] e1;
    logic [8:0] e2;
    logic [7:0] na;
    logic [7:0] nb;
    int lat;
    e1 = add8(8'h3C, 8'h4B, 1'b0);
    start8(8'h3C, 8'h4B, 1'b0, lat);
    na = 8'($urandom_range(0, 255));
    nb = 8'($urandom_range(0, 255));
    e2 = add8(na, nb, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      i8.in_valid = 1'b1; i8.a = 8'($urandom_range(0, 255)); i8.b = 8'($urandom_range(0, 255)); i8.cin = 1'b1;
      n_vec++;
      if (i8.out_valid !== 1'b1 || i8.in_ready !== 1'b0 || {i8.cout, i8.sum} !== e1) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b res=%b/%h, need 1/0/%b/%h",
                 k, i8.out_valid, i8.in_ready, i8.cout, i8.sum, e1[8], e1[7:0]);
      end
    end
    // Result handshake and a pending in_valid on the same edge
    @(negedge clk);
    i8.a = na; i8.b = nb; i8.cin = 1'b1; i8.out_ready = 1'b1;
    @(posedge clk);
    #1 i8.out_ready = 1'b0;
    n_vec++;
    if (i8.out_valid !== 1'b0 || i8.in_ready !== 1'b1 || i8.busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: got vld=%b rdy=%b busy=%b, need 0/1/0", i8.out_valid, i8.in_ready, i8.busy);
    end
    @(posedge clk);
    #1 i8.in_valid = 1'b0;
    n_vec++;
    if (i8.busy !== 1'b1 || i8.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_next_accept: got busy=%b rdy=%b, need 1/0", i8.busy, i8.in_ready);
    end
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!i8.out_valid && lat < 40);
    n_vec++;
    if (lat != 4 || {i8.cout, i8.sum} !== e2) begin
      n_err++;
      $display("FAIL bp_second: got lat=%0d res=%b/%h, need 4 %b/%h", lat, i8.cout, i8.sum, e2[8], e2[7:0]);
    end
    pop8();
  endtask

  task automatic test_mid_reset();
    int seen;
    @(negedge clk);
    i8.a = 8'h77; i8.b = 8'h19; i8.cin = 1'b1; i8.in_valid = 1'b1;
    @(posedge clk);
    #1 i8.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (i8.out_valid !== 1'b0 || i8.busy !== 1'b0 || i8.in_ready !== 1'b1 || i8.sum !== 8'h00 || i8.cout !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got vld=%b busy=%b rdy=%b res=%b/%h, need 0/0/1/0/00",
               i8.out_valid, i8.busy, i8.in_ready, i8.cout, i8.sum);
    end
`ifdef CLA_SEQ_SEG7_EN
    n_vec++;
    if (seg8 !== 7'b1000000) begin
      n_err++;
      $display("FAIL mid_reset_seg: got %b, need 1000000", seg8);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (i8.out_valid === 1'b1 || i8.busy === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL mid_reset_no_result: got %0d active cycles, need 0", seen);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] e;
    int lat;
    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      exp_q.push_back(add8(ra, rb, rc));
      start8(ra, rb, rc, lat);
      e = exp_q.pop_front();
      n_vec++;
      if (lat != 4 || {i8.cout, i8.sum} !== e) begin
        n_err++;
        $display("FAIL rand[%0d] %h+%h+%b: got lat=%0d res=%b/%h, need 4 %b/%h",
                 i, ra, rb, rc, lat, i8.cout, i8.sum, e[8], e[7:0]);
      end
`ifdef CLA_SEQ_SEG7_EN
      n_vec++;
      if (seg8 !== glyph(e[3:0])) begin
        n_err++;
        $display("FAIL rand_seg[%0d]: got %b, need %b", i, seg8, glyph(e[3:0]));
      end
`endif
      // Random consumer stall before accepting
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pop8();
    end
  endtask

  task automatic test_width2();
    logic [2:0] e;
    int lat;
    for (int va = 0; va < 4; va++) begin
      for (int vb = 0; vb < 4; vb++) begin
        for (int vc = 0; vc < 2; vc++) begin
          e = 3'(va + vb + vc);
          @(negedge clk);
          i2.a = 2'(va); i2.b = 2'(vb); i2.cin = 1'(vc); i2.in_valid = 1'b1; i2.out_ready = 1'b0;
          @(posedge clk);
          #1 i2.in_valid = 1'b0;
          lat = 0;
          do begin
            @(posedge clk); #1; lat++;
          end while (!i2.out_valid && lat < 20);
          n_vec++;
          if (lat != 1 || {i2.cout, i2.sum} !== e) begin
            n_err++;
            $display("FAIL w2 %0d+%0d+%0d: got lat=%0d res=%b/%b, need 1 %b/%b",
                     va, vb, vc, lat, i2.cout, i2.sum, e[2], e[1:0]);
          end
          @(negedge clk);
          i2.out_ready = 1'b1;
          @(posedge clk);
          #1 i2.out_ready = 1'b0;
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    i8.in_valid = 1'b0; i8.a = '0; i8.b = '0; i8.cin = 1'b0; i8.out_ready = 1'b0;
    i2.in_valid = 1'b0; i2.a = '0; i2.b = '0; i2.cin = 1'b0; i2.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_random();
    test_width2();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
